multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter M_EXT, default 1, meaning 1 enables the RV M-extension ops, 0 decodes funct7=0000001 as the base op.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 opcode  input  7  instruction opcode.
REQ-008 funct3  input  3  instruction funct3.
REQ-009 funct7  input  7  instruction funct7.
REQ-010 op_a  input  XLEN  first operand.
REQ-011 op_b  input  XLEN  second operand (register or immediate).
REQ-012 out_valid  output  1  result and bcond valid.
REQ-013 out_ready  input  1  consumer takes the result this cycle.
REQ-014 result  output  XLEN  operation result.
REQ-015 bcond  output  1  branch-taken flag; 0 for non-branch ops.
REQ-016 busy  output  1  high in CALC state.

Function
REQ-017 A request is accepted on a cycle with in_valid && in_ready; opcode/funct3/funct7/op_a/op_b are captured only then.
REQ-018 States: IDLE, CALC, DONE; IDLE->DONE on accepting a single-cycle op, IDLE->CALC on accepting a multi-cycle op, CALC->DONE when the iteration counter reaches XLEN, DONE->IDLE on out_ready with no new accept, DONE->DONE or DONE->CALC on out_ready with a simultaneous accept.
REQ-019 in_ready = 1 in IDLE, = out_ready in DONE, = 0 in CALC.
REQ-020 ARITHMETIC (0110011) and ARITHMETIC_IMM (0010011) decode funct3 to ADD, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND; funct7=0100000 selects SUB (ARITHMETIC only) and SRA (both opcodes).
REQ-021 Shift amount is op_b[log2(XLEN)-1:0]; SLT/SLTU return 1 or 0 zero-extended.
REQ-022 LOAD (0000011) and STORE (0100011) compute op_a + op_b regardless of funct3.
REQ-023 BRANCH (1100011) sets result = op_a - op_b and bcond per funct3: BEQ, BNE, BLT, BGE (signed), BLTU, BGEU (unsigned); funct3 010/011 give bcond=0.
REQ-024 Any other opcode computes ADD with bcond=0.
REQ-025 Single-cycle ops: out_valid asserted the cycle after accept (latency 1).
REQ-026 With M_EXT=1, ARITHMETIC with funct7=0000001 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by funct3, each multi-cycle.
REQ-027 Multiply: iterative shift-add over a 2*XLEN product, one bit per cycle; MUL returns low XLEN bits, MULH* return high XLEN bits with RV signedness.
REQ-028 Divide: restoring division, one quotient bit per cycle on magnitudes, sign fixed at completion.
REQ-029 Multi-cycle ops: out_valid asserted exactly XLEN+1 cycles after accept.
REQ-030 Divide by zero: DIV/DIVU quotient = all ones, REM/REMU = op_a.
REQ-031 Signed overflow (op_a = -2^(XLEN-1), op_b = -1): DIV = op_a, REM = 0.
REQ-032 result and bcond are held stable while out_valid && !out_ready.
REQ-033 Inputs are ignored (no capture, no state change) while in_ready = 0.

Reset
REQ-034 reset high at a clock edge forces IDLE, out_valid=0, busy=0, result=0, bcond=0, counter=0, in_ready=1 the following cycle.
REQ-035 reset mid-CALC or in DONE aborts the operation; the pending result is discarded and never presented.

Verification
REQ-036 ADD op_a=5, op_b=7, out_ready=1 -> out_valid one cycle after accept, result=12, bcond=0.
REQ-037 ARITHMETIC SUB funct7=0100000, op_a=3, op_b=5 -> result=0xFFFFFFFE; BRANCH BLT op_a=-1, op_b=1 -> bcond=1; BLTU same operands -> bcond=0.
REQ-038 MULHU op_a=0xFFFFFFFF, op_b=2 (XLEN=32) -> busy for 32 cycles, out_valid at accept+33, result=1; MUL same operands -> 0xFFFFFFFE.
REQ-039 DIV op_a=7, op_b=0 -> 0xFFFFFFFF; REM same -> 7; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-040 out_ready=0 for 5 cycles after out_valid -> result constant, in_ready=0; raise out_ready with in_valid -> result consumed and new op accepted same cycle.
REQ-041 reset asserted 10 cycles into a DIVU -> next cycle IDLE, out_valid=0, in_ready=1; subsequent ADD completes correctly.

Source files
------------

// File: rtl/multicycle_alu.sv
// Integer ALU with iterative RV M-extension multiply/divide.
// Latency: 1 cycle for base ops, XLEN+1 cycles for MUL*/DIV*/REM*.
// Backpressure: result held in DONE until out_ready; no new request accepted while computing.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid / in_ready   - request handshake; opcode/funct3/funct7/op_a/op_b captured on accept
//   out_valid / out_ready - result handshake; result and bcond valid while out_valid
//   result, bcond         - operation result and branch-taken flag
//   busy                  - high while an iterative op is in progress
module multicycle_alu #(
    parameter int XLEN  = 32,
    parameter int M_EXT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            bcond,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]     mcand_q, mcand_d;  // multiplicand or divisor magnitude
    logic [XLEN-1:0]     a_q, a_d;          // raw dividend, returned by REM on divide-by-zero
    logic [2:0]          f3_q, f3_d;
    logic                neg_q, neg_d;      // negate product / quotient at completion
    logic                neg_rem_q, neg_rem_d;
    logic                div0_q, div0_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                bcond_q, bcond_d;

    logic                accept;
    logic                mext_op;
    logic                alt;
    logic [SW-1:0]       shamt;
    logic [XLEN-1:0]     sc_res;
    logic                sc_bc;

    assign accept  = in_valid && in_ready;
    assign alt     = (funct7 == 7'b0100000);
    assign shamt   = op_b[SW-1:0];
    assign mext_op = (M_EXT != 0) && (opcode == OP_ARITH) && (funct7 == 7'b0000001);

    // Single-cycle datapath
    always_comb begin
        sc_res = op_a + op_b;
        sc_bc  = 1'b0;
        case (opcode)
            OP_ARITH, OP_ARITH_IMM: begin
                case (funct3)
                    3'b000:  sc_res = (opcode == OP_ARITH && alt) ? op_a - op_b : op_a + op_b;
                    3'b001:  sc_res = op_a << shamt;
                    3'b010:  sc_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                    3'b011:  sc_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
                    3'b100:  sc_res = op_a ^ op_b;
                    3'b101:  sc_res = alt ? XLEN'($signed(op_a) >>> shamt) : op_a >> shamt;
                    3'b110:  sc_res = op_a | op_b;
                    default: sc_res = op_a & op_b;
                endcase
            end
            OP_BRANCH: begin
                sc_res = op_a - op_b;
                case (funct3)
                    3'b000:  sc_bc = (op_a == op_b);
                    3'b001:  sc_bc = (op_a != op_b);
                    3'b100:  sc_bc = ($signed(op_a) < $signed(op_b));
                    3'b101:  sc_bc = ($signed(op_a) >= $signed(op_b));
                    3'b110:  sc_bc = (op_a < op_b);
                    3'b111:  sc_bc = (op_a >= op_b);
                    default: sc_bc = 1'b0;
                endcase
            end
            default: sc_res = op_a + op_b;  // LOAD, STORE and unknown opcodes
        endcase
    end

    // Operand setup: iterate on magnitudes, remember which signs to restore.
    logic            a_sgn, b_sgn, sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    assign a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_sgn = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sa    = a_sgn && op_a[XLEN-1];
    assign sb    = b_sgn && op_b[XLEN-1];
    assign mag_a = sa ? ({XLEN{1'b0}} - op_a) : op_a;
    assign mag_b = sb ? ({XLEN{1'b0}} - op_b) : op_b;

    // One shift-add multiply step: add multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole product right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // One restoring divide step: shift next dividend bit into the remainder, subtract if it fits.
    logic [XLEN:0]     div_tmp, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;
    assign div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge   = (div_tmp >= {1'b0, mcand_q});
    assign div_diff = div_tmp - {1'b0, mcand_q};
    assign div_rem  = div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0];
    assign div_next = {div_rem, acc_q[XLEN-2:0], div_ge};

    logic [2*XLEN-1:0] step_next, prod_fix;
    logic [XLEN-1:0]   quo, rem, fin_res;
    assign step_next = f3_q[2] ? div_next : mul_next;
    assign prod_fix  = neg_q ? ({(2*XLEN){1'b0}} - step_next) : step_next;
    assign quo       = step_next[XLEN-1:0];
    assign rem       = step_next[2*XLEN-1:XLEN];

    always_comb begin
        case (f3_q)
            3'b000:         fin_res = prod_fix[XLEN-1:0];
            3'b100, 3'b101: fin_res = div0_q ? {XLEN{1'b1}} : (neg_q ? ({XLEN{1'b0}} - quo) : quo);
            3'b110, 3'b111: fin_res = div0_q ? a_q : (neg_rem_q ? ({XLEN{1'b0}} - rem) : rem);
            default:        fin_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        a_d       = a_q;
        f3_d      = f3_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        result_d  = result_q;
        bcond_d   = bcond_q;

        case (state_q)
            S_CALC: begin
                acc_d = step_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    result_d = fin_res;
                    bcond_d  = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // An accept in DONE overrides the return to IDLE.
        if (accept) begin
            cnt_d = '0;
            if (mext_op) begin
                state_d   = S_CALC;
                f3_d      = funct3;
                acc_d     = {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
                mcand_d   = funct3[2] ? mag_b : mag_a;
                a_d       = op_a;
                neg_d     = sa ^ sb;
                neg_rem_d = sa;
                div0_d    = (op_b == {XLEN{1'b0}});
            end else begin
                state_d  = S_DONE;
                result_d = sc_res;
                bcond_d  = sc_bc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            a_q       <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            result_q  <= '0;
            bcond_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            a_q       <= a_d;
            f3_q      <= f3_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            result_q  <= result_d;
            bcond_q   <= bcond_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC);
    assign result    = result_q;
    assign bcond     = bcond_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed-vector bench for multicycle_alu (XLEN=32, M_EXT=1).
// Latency: checks 1-cycle and XLEN+1-cycle completion.
// Backpressure: exercises result hold under out_ready=0 and reset abort.
module tb_multicycle_alu;
    localparam logic [6:0] ARITH = 7'b0110011;
    localparam logic [6:0] IMM   = 7'b0010011;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] F7_0  = 7'b0000000;
    localparam logic [6:0] F7_A  = 7'b0100000;
    localparam logic [6:0] F7_M  = 7'b0000001;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        bcond;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_alu #(.XLEN(32), .M_EXT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .bcond     (bcond),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b);
        opcode = opc;
        funct3 = f3;
        funct7 = f7;
        op_a   = a;
        op_b   = b;
    endtask

    // Issue one request from IDLE with out_ready=1, wait for the result, check it, let it drain.
    task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_bc, input int exp_lat);
        int lat;
        int busy_n;
        set_req(opc, f3, f7, a, b);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " result"}, result, exp_res);
        chk({tag, " bcond"}, bcond, exp_bc);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy cycles"}, busy_n, exp_lat - 1);
        @(posedge clk); #1;
        chk({tag, " drained"}, out_valid, 1'b0);
    endtask

    initial begin
        logic seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_req(F7_0, 3'b000, F7_0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset result", result, 32'd0);
        chk("reset bcond", bcond, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single-cycle ops
        run_op("add",    ARITH, 3'b000, F7_0, 32'd5, 32'd7, 32'd12, 1'b0, 1);
        run_op("sub",    ARITH, 3'b000, F7_A, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("addi_alt", IMM, 3'b000, F7_A, 32'd3, 32'd5, 32'd8, 1'b0, 1);
        run_op("slli",   IMM,   3'b001, F7_0, 32'd1, 32'd33, 32'd2, 1'b0, 1);
        run_op("srai",   IMM,   3'b101, F7_A, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
        run_op("srl",    ARITH, 3'b101, F7_0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);
        run_op("slt",    ARITH, 3'b010, F7_0, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1);
        run_op("sltu",   ARITH, 3'b011, F7_0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1);
        run_op("xor",    ARITH, 3'b100, F7_0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0, 1);
        run_op("or",     ARITH, 3'b110, F7_0, 32'h00F0_0000, 32'h0000_000F, 32'h00F0_000F, 1'b0, 1);
        run_op("andi",   IMM,   3'b111, F7_0, 32'h1234_5678, 32'h0000_FF00, 32'h0000_5600, 1'b0, 1);
        run_op("load",   LOAD,  3'b010, F7_0, 32'd100, 32'hFFFF_FFFC, 32'd96, 1'b0, 1);
        run_op("store",  STORE, 3'b001, F7_A, 32'd100, 32'd4, 32'd104, 1'b0, 1);
        run_op("other",  JAL,   3'b000, F7_0, 32'd10, 32'd20, 32'd30, 1'b0, 1);
        run_op("blt",    BR,    3'b100, F7_0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1, 1);
        run_op("bltu",   BR,    3'b110, F7_0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("beq",    BR,    3'b000, F7_0, 32'd4, 32'd4, 32'd0, 1'b1, 1);
        run_op("bne",    BR,    3'b001, F7_0, 32'd4, 32'd4, 32'd0, 1'b0, 1);
        run_op("bge",    BR,    3'b101, F7_0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("bgeu",   BR,    3'b111, F7_0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1, 1);
        run_op("br010",  BR,    3'b010, F7_0, 32'd4, 32'd4, 32'd0, 1'b0, 1);

        // Multi-cycle ops
        run_op("mulhu",  ARITH, 3'b011, F7_M, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 33);
        run_op("mul",    ARITH, 3'b000, F7_M, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 33);
        run_op("mulh_nn", ARITH, 3'b001, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        run_op("mulh_min", ARITH, 3'b001, F7_M, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
        run_op("mulhsu", ARITH, 3'b010, F7_M, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("div0",   ARITH, 3'b100, F7_M, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("rem0",   ARITH, 3'b110, F7_M, 32'd7, 32'd0, 32'd7, 1'b0, 33);
        run_op("divu0",  ARITH, 3'b101, F7_M, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("remu0",  ARITH, 3'b111, F7_M, 32'd7, 32'd0, 32'd7, 1'b0, 33);
        run_op("div_ovf", ARITH, 3'b100, F7_M, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
        run_op("rem_ovf", ARITH, 3'b110, F7_M, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        run_op("div_neg", ARITH, 3'b100, F7_M, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        run_op("rem_neg", ARITH, 3'b110, F7_M, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("divu",   ARITH, 3'b101, F7_M, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        run_op("remu",   ARITH, 3'b111, F7_M, 32'd100, 32'd7, 32'd2, 1'b0, 33);

        // Backpressure: hold result, ignore requests while stalled, then consume + accept together
        set_req(ARITH, 3'b000, F7_0, 32'd1, 32'd2);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        set_req(ARITH, 3'b000, F7_A, 32'd10, 32'd4);  // stays presented, must be ignored
        chk("bp out_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp hold result", result, 32'd3);
            chk("bp in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        chk("bp still valid", out_valid, 1'b1);
        chk("bp final hold", result, 32'd3);
        out_ready = 1'b1;
        #1;
        chk("bp in_ready raised", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp new valid", out_valid, 1'b1);
        chk("bp new result", result, 32'd6);
        @(posedge clk); #1;
        chk("bp drained", out_valid, 1'b0);

        // Reset abort during DIVU
        set_req(ARITH, 3'b101, F7_M, 32'd100, 32'd7);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort busy before", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort out_valid", out_valid, 1'b0);
        chk("abort in_ready", in_ready, 1'b1);
        chk("abort busy", busy, 1'b0);
        chk("abort result", result, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort discarded", seen, 1'b0);
        run_op("add_after_rst", ARITH, 3'b000, F7_0, 32'd5, 32'd7, 32'd12, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no summary expected completion");
        $fatal(1);
    end

endmodule
